// File: rtl/ir_nec_tx_pkg.sv
// Shared definitions for the NEC infrared transmitter.
//   - nec_state_e : transmitter FSM states
//   - *_U         : NEC segment lengths in protocol time units
//   - NEC_BITS    : payload bits per frame (addr, ~addr, data, ~data)
package ir_nec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StGap
    } nec_state_e;

    localparam int unsigned LEAD_MARK_U  = 16;
    localparam int unsigned LEAD_SPACE_U = 8;
    localparam int unsigned BIT_MARK_U   = 1;
    localparam int unsigned ZERO_SPACE_U = 1;
    localparam int unsigned ONE_SPACE_U  = 3;
    localparam int unsigned STOP_U       = 1;
    localparam int unsigned FRAME_U      = 121;
    localparam int unsigned NEC_BITS     = 32;

endpackage

// File: rtl/ir_nec_tx_if.sv
// Request/status bundle of the NEC transmitter.
//   start    : frame request (master -> slave)
//   dataIn   : payload byte  (master -> slave)
//   IRDA_TXD : modulated IR LED drive (slave -> master)
//   busy     : frame in progress, gap included (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
interface ir_nec_tx_if;

    logic       start;
    logic [7:0] dataIn;
    logic       IRDA_TXD;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output dataIn,
        input  IRDA_TXD,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  dataIn,
        output IRDA_TXD,
        output busy,
        output done
    );

endinterface

// File: rtl/ir_nec_tx_carrier_gen.sv
// Carrier divider for IR marks.
//   CLOCK_50  : system clock
//   reset     : asynchronous active-high reset
//   en        : carrier runs while high; output held low otherwise
//   phase_clr : restart the carrier at its high phase (mark entry)
//   carrier   : registered square wave, CARRIER_HALF clocks high then low
module ir_carrier_gen #(
    parameter int unsigned CARRIER_HALF = 658
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    input  logic phase_clr,
    output logic carrier
);

    localparam int unsigned HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic          carrier_q, carrier_d;

    always_comb begin
        half_cnt_d = half_cnt_q;
        carrier_d  = carrier_q;
        if (phase_clr) begin
            half_cnt_d = '0;
            carrier_d  = 1'b1;
        end else if (!en) begin
            half_cnt_d = '0;
            carrier_d  = 1'b0;
        end else if (half_cnt_q == HW'(CARRIER_HALF - 1)) begin
            half_cnt_d = '0;
            carrier_d  = ~carrier_q;
        end else begin
            half_cnt_d = half_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            half_cnt_q <= '0;
            carrier_q  <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            carrier_q  <= carrier_d;
        end
    end

    assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter.
// On an accepted start it latches one byte and sends leader, ADDR, ~ADDR, data, ~data
// (LSB first), a stop burst and an inter-frame gap; marks carry the modulated carrier.
//   CLOCK_50 : system clock
//   reset    : asynchronous active-high reset
//   bus      : ir_nec_tx_if slave (start, dataIn in; IRDA_TXD, busy, done out)
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_HALF = 658,
    parameter int unsigned GAP_UNITS    = 71,
    parameter logic [7:0]  ADDR         = 8'h00
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    ir_nec_tx_if.slave  bus
);

    localparam int unsigned UCW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned GW  = $clog2(GAP_UNITS + 1);
    localparam int unsigned UW  = (GW > 5) ? GW : 5;

    nec_state_e     state_q, state_d;
    logic [UCW-1:0] unit_cnt_q, unit_cnt_d;
    logic [UW-1:0]  units_q, units_d;
    logic [4:0]     bit_idx_q, bit_idx_d;
    logic [31:0]    shift_q, shift_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [UW-1:0]  dur;
    logic           unit_end;
    logic           state_end;
    logic           mark_d;
    logic           phase_clr;
    logic           carrier;

    // Length of the current state in units; a bit space depends on the bit being sent.
    always_comb begin
        dur = UW'(1);
        case (state_q)
            StLeadMark:  dur = UW'(LEAD_MARK_U);
            StLeadSpace: dur = UW'(LEAD_SPACE_U);
            StBitMark:   dur = UW'(BIT_MARK_U);
            StBitSpace:  dur = shift_q[0] ? UW'(ONE_SPACE_U) : UW'(ZERO_SPACE_U);
            StStopMark:  dur = UW'(STOP_U);
            StGap:       dur = UW'(GAP_UNITS);
            default:     dur = UW'(1);
        endcase
    end

    assign unit_end  = (unit_cnt_q == UCW'(UNIT_CYCLES - 1));
    assign state_end = unit_end && (units_q == dur - UW'(1));

    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        units_d    = units_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;

        if (state_q != StIdle) begin
            if (unit_end) begin
                unit_cnt_d = '0;
                units_d    = units_q + 1'b1;
            end else begin
                unit_cnt_d = unit_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLeadMark;
                end
            end
            StLeadMark:  if (state_end) state_d = StLeadSpace;
            StLeadSpace: if (state_end) state_d = StBitMark;
            StBitMark:   if (state_end) state_d = StBitSpace;
            StBitSpace: begin
                if (state_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    state_d   = (bit_idx_q == 5'(NEC_BITS - 1)) ? StStopMark : StBitMark;
                end
            end
            StStopMark:  if (state_end) state_d = StGap;
            StGap: begin
                if (state_end) begin
                    done_d  = 1'b1;
                    // A held start chains straight into the next frame.
                    state_d = bus.start ? StLeadMark : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            unit_cnt_d = '0;
            units_d    = '0;
        end

        // Frame acceptance: from IDLE or the last gap cycle.
        if (state_d == StLeadMark && state_q != StLeadMark) begin
            shift_d   = {~bus.dataIn, bus.dataIn, ~ADDR, ADDR};
            bit_idx_d = '0;
        end
    end

    assign busy_d    = (state_d != StIdle);
    assign mark_d    = (state_d == StLeadMark) || (state_d == StBitMark) ||
                       (state_d == StStopMark);
    assign phase_clr = mark_d && (state_d != state_q);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            unit_cnt_q <= '0;
            units_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .en        (mark_d),
        .phase_clr (phase_clr),
        .carrier   (carrier)
    );

    assign bus.IRDA_TXD = carrier;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx with short timing (8-clock units, 2-clock carrier half).
module tb_ir_nec_tx;

    localparam int unsigned UC        = 8;
    localparam int unsigned CH        = 2;
    localparam int unsigned GU        = 4;
    localparam int unsigned FRAME_CYC = (121 + GU) * UC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ir_nec_tx_if bus ();

    ir_nec_tx #(
        .UNIT_CYCLES  (UC),
        .CARRIER_HALF (CH),
        .GAP_UNITS    (GU),
        .ADDR         (8'h00)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic exp_wave [FRAME_CYC];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Reference waveform of one frame, built from the NEC segment list.
    task automatic build_wave(input logic [7:0] d);
        int pos = 0;
        logic [31:0] word;
        word = {~d, d, 8'hFF, 8'h00};
        for (int j = 0; j < 16 * int'(UC); j++) exp_wave[pos++] = ((j % 4) < 2);
        for (int j = 0; j < 8 * int'(UC); j++) exp_wave[pos++] = 1'b0;
        for (int b = 0; b < 32; b++) begin
            for (int j = 0; j < int'(UC); j++) exp_wave[pos++] = ((j % 4) < 2);
            for (int j = 0; j < (word[b] ? 3 : 1) * int'(UC); j++) exp_wave[pos++] = 1'b0;
        end
        for (int j = 0; j < int'(UC); j++) exp_wave[pos++] = ((j % 4) < 2);
        for (int j = 0; j < int'(GU * UC); j++) exp_wave[pos++] = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns at the negedge
    // following the final gap cycle (the done cycle).
    task automatic check_frame(input logic [7:0] d, input bit inject, input bit keep_start,
                               input logic [7:0] late_data, input bit expect_b2b);
        int dones = 0;
        build_wave(d);
        for (int i = 0; i < int'(FRAME_CYC); i++) begin
            chk("txd", i, 32'(bus.IRDA_TXD), 32'(exp_wave[i]));
            chk("busy", i, 32'(bus.busy), 32'd1);
            if (i > 0 && bus.done === 1'b1) dones++;
            if (i == 0 && !keep_start) bus.start = 1'b0;
            if (inject && i == 300) begin
                bus.start  = 1'b1;
                bus.dataIn = 8'h3C;
            end
            if (inject && i == 301) bus.start = 1'b0;
            if (i == 500) bus.dataIn = late_data;
            @(negedge clk);
        end
        chk("done_in_frame", 0, 32'(dones), 32'd0);
        chk("done_end", int'(FRAME_CYC), 32'(bus.done), 32'd1);
        chk("busy_end", int'(FRAME_CYC), 32'(bus.busy), 32'(expect_b2b));
        chk("txd_end", int'(FRAME_CYC), 32'(bus.IRDA_TXD), 32'(expect_b2b));
        if (!expect_b2b) begin
            @(negedge clk);
            chk("done_one_cycle", int'(FRAME_CYC) + 1, 32'(bus.done), 32'd0);
            chk("busy_idle", int'(FRAME_CYC) + 1, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.dataIn = 8'h00;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", 0, 32'(bus.IRDA_TXD), 32'd0);
        chk("rst_busy", 0, 32'(bus.busy), 32'd0);
        chk("rst_done", 0, 32'(bus.done), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("rst_hold_txd", i, 32'(bus.IRDA_TXD), 32'd0);
            chk("rst_hold_busy", i, 32'(bus.busy), 32'd0);
            chk("rst_hold_done", i, 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 0, 32'(bus.busy), 32'd0);

        // Single frame 8'hA5, with a rejected start and a dataIn change mid-frame.
        bus.start  = 1'b1;
        bus.dataIn = 8'hA5;
        @(negedge clk);
        check_frame(8'hA5, 1'b1, 1'b0, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_after", 0, 32'(bus.busy), 32'd0);

        // Back-to-back: held start chains a second frame with the byte present at the
        // done edge.
        bus.start  = 1'b1;
        bus.dataIn = 8'h5A;
        @(negedge clk);
        check_frame(8'h5A, 1'b0, 1'b1, 8'h81, 1'b1);
        check_frame(8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        repeat (3) @(negedge clk);

        // Reset during bit 10 (cycles 384..415 of the frame).
        bus.start  = 1'b1;
        bus.dataIn = 8'h96;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (390) @(negedge clk);
        chk("pre_rst_busy", 390, 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", 0, 32'(bus.IRDA_TXD), 32'd0);
        chk("midrst_busy", 0, 32'(bus.busy), 32'd0);
        chk("midrst_done", 0, 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_done", i, 32'(bus.done), 32'd0);
            chk("post_rst_busy", i, 32'(bus.busy), 32'd0);
            chk("post_rst_txd", i, 32'(bus.IRDA_TXD), 32'd0);
        end

        // Fresh frame after the aborted one.
        bus.start = 1'b1;
        @(negedge clk);
        check_frame(8'h96, 1'b0, 1'b0, 8'h96, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
